// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, BCD
// digit width and the per-digit wrap limits.
// Build option: TIMER_CTRL_SEXAGESIMAL_EN makes digits 1 and 3 run 0-5.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] LIMIT_DEC = 4'd9;
  localparam logic [BCD_W-1:0] LIMIT_SEX = 4'd5;

  // Wrap limit of digit idx. The tens-of-seconds and tens-of-minutes
  // positions are base 6 in the mm:ss build.
  function automatic logic [BCD_W-1:0] digit_limit(input int idx);
`ifdef TIMER_CTRL_SEXAGESIMAL_EN
    if (idx == 1 || idx == 3) return LIMIT_SEX;
    return LIMIT_DEC;
`else
    if (idx < 0) return LIMIT_SEX;
    return LIMIT_DEC;
`endif
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One counter digit: increments on inc, wraps at LIMIT, and raises carry
// combinationally on the increment that wraps it.
module bcd_digit
  import timer_ctrl_pkg::*;
#(
  parameter logic [BCD_W-1:0] LIMIT = LIMIT_DEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  // Ripple carry: this digit wraps in the same cycle it is stepped.
  assign carry = inc && (q == LIMIT);

  // Digit register; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == LIMIT) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch controller: IDLE/COUNT/PAUSE/LAP FSM driving a chain of BCD
// digits, with a frozen lap display and a sticky overflow flag.
// Build option: TIMER_CTRL_SEXAGESIMAL_EN selects mm:ss digit limits.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    start_pause,
  input  logic                    lap,
  input  logic                    clear,
  output logic [1:0]              state,
  output logic [BCD_W*DIGITS-1:0] disp,
  output logic                    running,
  output logic                    ovf
);

  state_t                  state_q;
  logic [BCD_W*DIGITS-1:0] count;
  logic [BCD_W*DIGITS-1:0] lap_q;
  logic [DIGITS:0]         inc_chain;
  logic                    count_en;
  logic                    clr_cnt;

  // Counting depends only on the current registered state, so a tick on the
  // way out of COUNT/LAP still counts and one on the way in does not.
  assign count_en = tick && (state_q == ST_COUNT || state_q == ST_LAP);

  // Clear is honoured only in PAUSE and only when no higher-priority event
  // is present in the same cycle.
  assign clr_cnt = (state_q == ST_PAUSE) && clear && !start_pause && !lap;

  assign inc_chain[0] = count_en;

  // Digit chain, least significant digit first.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit #(
      .LIMIT(digit_limit(g))
    ) u_digit (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc_chain[g]),
      .clr  (clr_cnt),
      .q    (count[g*BCD_W +: BCD_W]),
      .carry(inc_chain[g+1])
    );
  end

  // Control FSM with the lap register and overflow flag it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lap_q   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pause) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (start_pause) begin
            state_q <= ST_PAUSE;
          end else if (lap) begin
            state_q <= ST_LAP;
            lap_q   <= count;
          end
        end
        ST_PAUSE: begin
          if (start_pause) state_q <= ST_COUNT;
          else if (clr_cnt) state_q <= ST_IDLE;
        end
        ST_LAP: begin
          if (start_pause) state_q <= ST_PAUSE;
          else if (lap) state_q <= ST_COUNT;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (clr_cnt) ovf <= 1'b0;
      else if (inc_chain[DIGITS]) ovf <= 1'b1;
    end
  end

  // Output decodes of registered state.
  assign state   = state_q;
  assign running = (state_q == ST_COUNT) || (state_q == ST_LAP);
  assign disp    = (state_q == ST_LAP) ? lap_q : count;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (DIGITS=4). Expected values
// follow TIMER_CTRL_SEXAGESIMAL_EN when it is defined for the build.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_pause = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  state;
  logic [15:0] disp;
  logic        running;
  logic        ovf;

  int errors = 0;
  int checks = 0;

`ifdef TIMER_CTRL_SEXAGESIMAL_EN
  localparam int          FULL_TICKS = 3600;
  localparam logic [15:0] ALL_MAX    = 16'h5959;
  localparam logic [15:0] AT_60      = 16'h0100;
`else
  localparam int          FULL_TICKS = 10000;
  localparam logic [15:0] ALL_MAX    = 16'h9999;
  localparam logic [15:0] AT_60      = 16'h0060;
`endif

  timer_ctrl #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_pause(start_pause),
    .lap        (lap),
    .clear      (clear),
    .state      (state),
    .disp       (disp),
    .running    (running),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given inputs; outputs settle by #1 after the edge.
  task automatic step(input logic sp, input logic lp, input logic cl, input logic tk);
    start_pause = sp;
    lap         = lp;
    clear       = cl;
    tick        = tk;
    @(posedge clk);
    #1;
    start_pause = 1'b0;
    lap         = 1'b0;
    clear       = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got=%h exp=0000", disp); end
    checks++;
    if (running !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags got running=%b ovf=%b exp 0 0", running, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_run;
    step(1'b0, 1'b1, 1'b1, 1'b1);  // lap/clear ignored in IDLE, tick not counted
    checks++;
    if (state !== 2'b00 || disp !== 16'h0000) begin
      errors++; $display("FAIL idle_ignore got state=%b disp=%h exp 00 0000", state, disp);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);  // tick on entry into COUNT does not count
    checks++;
    if (state !== 2'b01 || disp !== 16'h0000) begin
      errors++; $display("FAIL start_entry got state=%b disp=%h exp 01 0000", state, disp);
    end
    ticks(12);
    checks++;
    if (state !== 2'b01 || disp !== 16'h0012 || running !== 1'b1) begin
      errors++; $display("FAIL run_12 got state=%b disp=%h running=%b exp 01 0012 1", state, disp, running);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);  // clear ignored while running
    checks++;
    if (state !== 2'b01 || disp !== 16'h0012) begin
      errors++; $display("FAIL clear_in_count got state=%b disp=%h exp 01 0012", state, disp);
    end
  endtask

  task automatic test_pause_clear;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b10 || running !== 1'b0) begin
      errors++; $display("FAIL pause_state got state=%b running=%b exp 10 0", state, running);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (disp !== 16'h0012) begin errors++; $display("FAIL pause_hold got=%h exp=0012", disp); end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b00 || disp !== 16'h0000) begin
      errors++; $display("FAIL pause_clear got state=%b disp=%h exp 00 0000", state, disp);
    end
  endtask

  task automatic test_lap;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    checks++;
    if (state !== 2'b11 || disp !== 16'h0005 || running !== 1'b1) begin
      errors++; $display("FAIL lap_freeze got state=%b disp=%h running=%b exp 11 0005 1", state, disp, running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b01 || disp !== 16'h0015) begin
      errors++; $display("FAIL lap_resume got state=%b disp=%h exp 01 0015", state, disp);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);  // lap captures pre-increment value
    checks++;
    if (state !== 2'b11 || disp !== 16'h0015) begin
      errors++; $display("FAIL lap_capture got state=%b disp=%h exp 11 0015", state, disp);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);  // LAP->PAUSE, tick on exit counts
    checks++;
    if (state !== 2'b10 || disp !== 16'h0017) begin
      errors++; $display("FAIL lap_to_pause got state=%b disp=%h exp 10 0017", state, disp);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b10 || disp !== 16'h0008) begin
      errors++; $display("FAIL simul_count got state=%b disp=%h exp 10 0008", state, disp);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);  // start_pause beats clear in PAUSE
    checks++;
    if (state !== 2'b01 || disp !== 16'h0008) begin
      errors++; $display("FAIL simul_pause got state=%b disp=%h exp 01 0008", state, disp);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_carry;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59);
    checks++;
    if (disp !== 16'h0059) begin errors++; $display("FAIL carry_59 got=%h exp=0059", disp); end
    ticks(1);
    checks++;
    if (disp !== AT_60) begin errors++; $display("FAIL carry_60 got=%h exp=%h", disp, AT_60); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(FULL_TICKS - 1);
    checks++;
    if (disp !== ALL_MAX || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_max got disp=%h ovf=%b exp %h 0", disp, ovf, ALL_MAX);
    end
    ticks(1);
    checks++;
    if (disp !== 16'h0000 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_wrap got disp=%h ovf=%b exp 0000 1", disp, ovf);
    end
    ticks(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (disp !== 16'h0003 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got disp=%h ovf=%b exp 0003 1", disp, ovf);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b00 || disp !== 16'h0000 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got state=%b disp=%h ovf=%b exp 00 0000 0", state, disp, ovf);
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || disp !== 16'h0000 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset got state=%b disp=%h running=%b exp 00 0000 0", state, disp, running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b00 || disp !== 16'h0000) begin
      errors++; $display("FAIL post_reset got state=%b disp=%h exp 00 0000", state, disp);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause_clear();
    test_lap();
    test_simultaneous();
    test_carry();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
